// File: rtl/reflex_pkg.sv
// Shared definitions for the reflex trainer round sequencer.
// Latency: n/a (types, widths and helpers only).
// Backpressure: n/a.
package reflex_pkg;

    localparam int MS_W  = 10;
    localparam int CNT_W = 8;

    // Best reaction value meaning "no hit yet this game".
    localparam logic [MS_W-1:0] REACT_INIT = 10'd1023;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GAP    = 3'd1,
        ST_SPAWN  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic logic [MS_W-1:0] min_ms(input logic [MS_W-1:0] a,
                                               input logic [MS_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/round_timer.sv
// Millisecond counter for GAP and ACTIVE phases, with terminal match against a runtime limit.
// Latency: count_o updates one cycle after en_i/clr_i; match_o is combinational on the current tick.
// Backpressure: none; counts every enabled tick.
//
// Ports:
//   clk, rst      clock, async active-high reset
//   clr_i         synchronous clear (wins over en_i)
//   en_i          advance by one (qualified 1 ms tick)
//   limit_i       last count value of the current phase
//   count_o       current count
//   match_o       high on the enabled tick where count_o == limit_i
module round_timer
    import reflex_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic [MS_W-1:0] limit_i,
    output logic [MS_W-1:0] count_o,
    output logic            match_o
);

    logic [MS_W-1:0] count_q;
    logic [MS_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign match_o = en_i && (count_q == limit_i);

endmodule

// File: rtl/reflex_round_ctrl.sv
// Reflex trainer game sequencer: schedules target rounds, times responses, tallies hits/misses.
// Latency: every output is registered; events sampled at edge M are visible after edge M.
// Backpressure: none; start/hit/tick_ms are single-cycle strobes consumed when the state allows.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   start             begin a game (accepted in IDLE and DONE)
//   abort             synchronous return to IDLE, highest priority
//   tick_ms           1 ms strobe
//   hit               player touched the current target
//   new_ball          one-cycle request to the ball generator (SPAWN)
//   ball_visible      target drawable / hittable (ACTIVE)
//   game_over         high in DONE
//   state             FSM state, reflex_pkg encoding
//   score, misses, round_cnt, last_reaction_ms, best_reaction_ms   game statistics
module reflex_round_ctrl
    import reflex_pkg::*;
#(
    parameter int ROUNDS     = 10,
    parameter int TIMEOUT_MS = 1000,
    parameter int GAP_MS     = 500,
    parameter int MAX_MISSES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             tick_ms,
    input  logic             hit,
    output logic             new_ball,
    output logic             ball_visible,
    output logic             game_over,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] score,
    output logic [CNT_W-1:0] misses,
    output logic [CNT_W-1:0] round_cnt,
    output logic [MS_W-1:0]  last_reaction_ms,
    output logic [MS_W-1:0]  best_reaction_ms
);

    localparam logic [MS_W-1:0]  GAP_LAST     = MS_W'(GAP_MS - 1);
    localparam logic [MS_W-1:0]  TIMEOUT_LAST = MS_W'(TIMEOUT_MS - 1);
    localparam logic [CNT_W-1:0] ROUNDS_C     = CNT_W'(ROUNDS);
    localparam logic [CNT_W-1:0] MAX_MISS_C   = CNT_W'(MAX_MISSES);

    state_t state_q, state_d;

    logic [CNT_W-1:0] score_q, score_d;
    logic [CNT_W-1:0] misses_q, misses_d;
    logic [CNT_W-1:0] round_q, round_d;
    logic [MS_W-1:0]  last_q, last_d;
    logic [MS_W-1:0]  best_q, best_d;

    logic new_ball_q, new_ball_d;
    logic visible_q, visible_d;
    logic over_q, over_d;

    // Timer interface
    logic [MS_W-1:0] tmr_count;
    logic [MS_W-1:0] tmr_limit;
    logic            tmr_match;
    logic            tmr_en;
    logic            tmr_clr;

    // Qualified events; abort masks everything else.
    logic start_ev;
    logic hit_ev;
    logic miss_ev;
    logic game_end;

    assign start_ev = !abort && start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign hit_ev   = !abort && hit && (state_q == ST_ACTIVE);
    // A hit on the final tick takes precedence over the timeout.
    assign miss_ev  = !abort && !hit && tmr_match && (state_q == ST_ACTIVE);

    // The timer only runs in the two timed phases; the limit follows the phase.
    assign tmr_en    = tick_ms && (state_q == ST_GAP || state_q == ST_ACTIVE);
    assign tmr_limit = (state_q == ST_GAP) ? GAP_LAST : TIMEOUT_LAST;
    // Every phase starts from zero, so any state change (or abort) clears it.
    assign tmr_clr   = abort || (state_d != state_q);

    round_timer u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .limit_i (tmr_limit),
        .count_o (tmr_count),
        .match_o (tmr_match)
    );

    // Score datapath: next values of the game statistics.
    always_comb begin
        score_d  = score_q;
        misses_d = misses_q;
        round_d  = round_q;
        last_d   = last_q;
        best_d   = best_q;
        if (start_ev) begin
            score_d  = '0;
            misses_d = '0;
            round_d  = '0;
            last_d   = '0;
            best_d   = REACT_INIT;
        end else if (hit_ev) begin
            score_d = score_q + 1'b1;
            round_d = round_q + 1'b1;
            last_d  = tmr_count;
            best_d  = min_ms(best_q, tmr_count);
        end else if (miss_ev) begin
            misses_d = misses_q + 1'b1;
            round_d  = round_q + 1'b1;
        end
    end

    // Decided on the post-event counts so the final round lands directly in DONE.
    assign game_end = (round_d == ROUNDS_C) || (misses_d == MAX_MISS_C);

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) state_d = ST_GAP;
                end
                ST_GAP: begin
                    if (tmr_match) state_d = ST_SPAWN;
                end
                ST_SPAWN: begin
                    state_d = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (hit_ev || miss_ev) begin
                        state_d = game_end ? ST_DONE : ST_GAP;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // FSM: output logic, decoded from the next state so the flags register
    // alongside the state they describe.
    always_comb begin
        new_ball_d = (state_d == ST_SPAWN);
        visible_d  = (state_d == ST_ACTIVE);
        over_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score_q    <= '0;
            misses_q   <= '0;
            round_q    <= '0;
            last_q     <= '0;
            best_q     <= REACT_INIT;
            new_ball_q <= 1'b0;
            visible_q  <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            score_q    <= score_d;
            misses_q   <= misses_d;
            round_q    <= round_d;
            last_q     <= last_d;
            best_q     <= best_d;
            new_ball_q <= new_ball_d;
            visible_q  <= visible_d;
            over_q     <= over_d;
        end
    end

    assign new_ball         = new_ball_q;
    assign ball_visible     = visible_q;
    assign game_over        = over_q;
    assign state            = state_q;
    assign score            = score_q;
    assign misses           = misses_q;
    assign round_cnt        = round_q;
    assign last_reaction_ms = last_q;
    assign best_reaction_ms = best_q;

endmodule

// File: tb/tb_reflex_round_ctrl.sv
// Directed bench for reflex_round_ctrl with ROUNDS=3, TIMEOUT_MS=20, GAP_MS=5, MAX_MISSES=2.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_reflex_round_ctrl;

    localparam int ROUNDS     = 3;
    localparam int TIMEOUT_MS = 20;
    localparam int GAP_MS     = 5;
    localparam int MAX_MISSES = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       tick_ms;
    logic       hit;
    logic       new_ball;
    logic       ball_visible;
    logic       game_over;
    logic [2:0] state;
    logic [7:0] score;
    logic [7:0] misses;
    logic [7:0] round_cnt;
    logic [9:0] last_reaction_ms;
    logic [9:0] best_reaction_ms;

    int vectors     = 0;
    int miscompares = 0;

    reflex_round_ctrl #(
        .ROUNDS     (ROUNDS),
        .TIMEOUT_MS (TIMEOUT_MS),
        .GAP_MS     (GAP_MS),
        .MAX_MISSES (MAX_MISSES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .tick_ms          (tick_ms),
        .hit              (hit),
        .new_ball         (new_ball),
        .ball_visible     (ball_visible),
        .game_over        (game_over),
        .state            (state),
        .score            (score),
        .misses           (misses),
        .round_cnt        (round_cnt),
        .last_reaction_ms (last_reaction_ms),
        .best_reaction_ms (best_reaction_ms)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs GAP until new_ball appears (bounded), then steps into ACTIVE.
    task automatic gap_to_active(input int exp_ticks);
        int n;
        n = 0;
        while (new_ball !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check("gap_ticks", n, exp_ticks);
        check("spawn_state", state, 2);
        step();
        check("active_state", state, 3);
        check("new_ball_fall", new_ball, 0);
        check("ball_visible_rise", ball_visible, 1);
    endtask

    task automatic do_hit();
        hit = 1'b1;
        step();
        hit = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        tick_ms = 1'b1;
        hit     = 1'b0;
        #12;
        check("rst_state", state, 0);
        check("rst_score", score, 0);
        check("rst_misses", misses, 0);
        check("rst_round", round_cnt, 0);
        check("rst_last", last_reaction_ms, 0);
        check("rst_best", best_reaction_ms, 1023);
        check("rst_new_ball", new_ball, 0);
        check("rst_visible", ball_visible, 0);
        check("rst_game_over", game_over, 0);
        rst = 1'b0;
        step();
        step();
        check("idle_hold", state, 0);

        // Game 1: three hits at 7, 4, 9 ms.
        pulse_start();
        check("start_to_gap", state, 1);
        gap_to_active(5);
        repeat (7) step();
        do_hit();
        check("g1r1_score", score, 1);
        check("g1r1_last", last_reaction_ms, 7);
        check("g1r1_best", best_reaction_ms, 7);
        check("g1r1_state", state, 1);
        check("g1r1_visible_drop", ball_visible, 0);
        gap_to_active(5);
        repeat (4) step();
        do_hit();
        check("g1r2_score", score, 2);
        check("g1r2_last", last_reaction_ms, 4);
        check("g1r2_best", best_reaction_ms, 4);
        gap_to_active(5);
        repeat (9) step();
        do_hit();
        check("g1_score", score, 3);
        check("g1_last", last_reaction_ms, 9);
        check("g1_best", best_reaction_ms, 4);
        check("g1_misses", misses, 0);
        check("g1_round", round_cnt, 3);
        check("g1_state", state, 4);
        check("g1_game_over", game_over, 1);
        do_hit();
        check("done_hit_score", score, 3);
        check("done_hit_last", last_reaction_ms, 9);
        check("done_hit_state", state, 4);

        // Game 2: two timeouts end the game early.
        pulse_start();
        check("g2_state", state, 1);
        check("g2_clr_score", score, 0);
        check("g2_clr_best", best_reaction_ms, 1023);
        check("g2_game_over_drop", game_over, 0);
        gap_to_active(5);
        repeat (19) step();
        check("g2r1_still_active", state, 3);
        check("g2r1_no_miss_yet", misses, 0);
        step();
        check("g2r1_misses", misses, 1);
        check("g2r1_round", round_cnt, 1);
        check("g2r1_state", state, 1);
        gap_to_active(5);
        repeat (20) step();
        check("g2_state_done", state, 4);
        check("g2_misses", misses, 2);
        check("g2_round", round_cnt, 2);
        check("g2_best", best_reaction_ms, 1023);
        check("g2_game_over", game_over, 1);

        // Game 3: hit in GAP ignored, hit on the timeout tick, then abort with hit.
        pulse_start();
        hit = 1'b1;
        step();
        hit = 1'b0;
        check("gap_hit_score", score, 0);
        check("gap_hit_round", round_cnt, 0);
        check("gap_hit_state", state, 1);
        gap_to_active(4);
        repeat (19) step();
        do_hit();
        check("tie_score", score, 1);
        check("tie_misses", misses, 0);
        check("tie_last", last_reaction_ms, 19);
        check("tie_state", state, 1);
        gap_to_active(5);
        repeat (3) step();
        hit   = 1'b1;
        abort = 1'b1;
        step();
        hit   = 1'b0;
        abort = 1'b0;
        check("abort_state", state, 0);
        check("abort_score", score, 1);
        check("abort_round", round_cnt, 1);
        check("abort_visible", ball_visible, 0);
        step();
        check("abort_idle_hold", state, 0);
        pulse_start();
        check("restart_state", state, 1);
        check("restart_score", score, 0);
        check("restart_round", round_cnt, 0);
        check("restart_last", last_reaction_ms, 0);
        check("restart_best", best_reaction_ms, 1023);

        // Async reset mid-GAP with non-zero statistics.
        gap_to_active(5);
        repeat (6) step();
        do_hit();
        check("prerst_score", score, 1);
        check("prerst_best", best_reaction_ms, 6);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", state, 0);
        check("async_rst_score", score, 0);
        check("async_rst_round", round_cnt, 0);
        check("async_rst_last", last_reaction_ms, 0);
        check("async_rst_best", best_reaction_ms, 1023);
        #10;
        rst = 1'b0;
        step();
        check("post_rst_idle", state, 0);
        pulse_start();
        check("post_rst_gap", state, 1);
        gap_to_active(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
